// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX -> EX bundle: decoded instruction fields in, registered
// EX-stage fields and fetch write-enables out.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] IF_ID_RS, IF_ID_RT, IF_ID_RD;
  logic [DATA_W-1:0] ID_Data1, ID_Data2, ID_Imm;
  logic [7:0]        ID_Ctrl;
  logic              Flush, Hold;

  logic [REG_AW-1:0] ID_EX_RS, ID_EX_RT, ID_EX_RegWriteAdd;
  logic [DATA_W-1:0] ID_EX_Data1, ID_EX_Data2, ID_EX_Imm;
  logic [7:0]        ID_EX_Ctrl;
  logic              PC_Write, IF_ID_Write;
  logic [CNT_W-1:0]  Stall_Count;

  // pipeline register side
  modport slave (
    input  IF_ID_RS, IF_ID_RT, IF_ID_RD, ID_Data1, ID_Data2, ID_Imm,
           ID_Ctrl, Flush, Hold,
    output ID_EX_RS, ID_EX_RT, ID_EX_RegWriteAdd, ID_EX_Data1, ID_EX_Data2,
           ID_EX_Imm, ID_EX_Ctrl, PC_Write, IF_ID_Write, Stall_Count
  );

  // decode / driver side
  modport master (
    output IF_ID_RS, IF_ID_RT, IF_ID_RD, ID_Data1, ID_Data2, ID_Imm,
           ID_Ctrl, Flush, Hold,
    input  ID_EX_RS, ID_EX_RT, ID_EX_RegWriteAdd, ID_EX_Data1, ID_EX_Data2,
           ID_EX_Imm, ID_EX_Ctrl, PC_Write, IF_ID_Write, Stall_Count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush
// (remembered across a downstream hold) and a saturating stall counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] imm;
    logic [7:0]        ctrl;
  } fields_t;

  fields_t          fields_q, fields_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu, fl;

  // Load in EX whose rt matches either source slot in ID. Conservative:
  // rt in ID may only be a destination, but we stall anyway. $0 never stalls.
  always_comb begin
    lu = fields_q.ctrl[5] && (fields_q.rt != '0) &&
         ((fields_q.rt == bus.IF_ID_RS) || (fields_q.rt == bus.IF_ID_RT));
    fl = bus.Flush | flush_pend_q;
  end

  // Wrong-path instruction in ID is being squashed, so a flush cancels the stall
  assign bus.PC_Write    = ~bus.Hold & ~(lu & ~fl);
  assign bus.IF_ID_Write = ~bus.Hold & ~(lu & ~fl);

  assign bus.ID_EX_RS          = fields_q.rs;
  assign bus.ID_EX_RT          = fields_q.rt;
  assign bus.ID_EX_RegWriteAdd = fields_q.wa;
  assign bus.ID_EX_Data1       = fields_q.d1;
  assign bus.ID_EX_Data2       = fields_q.d2;
  assign bus.ID_EX_Imm         = fields_q.imm;
  assign bus.ID_EX_Ctrl        = fields_q.ctrl;
  assign bus.Stall_Count       = stall_cnt_q;

  // Next-state: hold > flush > load-use bubble > capture
  always_comb begin
    fields_d     = fields_q;
    flush_pend_d = flush_pend_q;
    stall_cnt_d  = stall_cnt_q;
    if (bus.Hold) begin
      // a flush seen while frozen must still squash on the first free edge
      if (bus.Flush) flush_pend_d = 1'b1;
    end else if (fl) begin
      fields_d     = '0;
      flush_pend_d = 1'b0;
    end else if (lu) begin
      // zeroed rs/rt keep forwarding (which ignores $0) out of the bubble
      fields_d = '0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      fields_d.rs   = bus.IF_ID_RS;
      fields_d.rt   = bus.IF_ID_RT;
      fields_d.wa   = bus.ID_Ctrl[2] ? bus.IF_ID_RD : bus.IF_ID_RT;
      fields_d.d1   = bus.ID_Data1;
      fields_d.d2   = bus.ID_Data2;
      fields_d.imm  = bus.ID_Imm;
      fields_d.ctrl = bus.ID_Ctrl;
    end
  end

  // State registers, async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields_q     <= '0;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      fields_q     <= fields_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scenario bench for id_ex_stage: expected ID/EX contents are queued when
// stimulus is applied and compared one cycle later.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  bus4 ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct packed {
    logic [4:0]  rs, rt, wa;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
    logic [15:0] cnt;
  } obs_t;

  obs_t       sb[$];
  logic [3:0] sb4[$];
  obs_t       act, exp_o;
  int         vec = 0;
  int         errs = 0;

  function automatic obs_t obs();
    obs_t o;
    o.rs = bus.ID_EX_RS;  o.rt = bus.ID_EX_RT;  o.wa = bus.ID_EX_RegWriteAdd;
    o.d1 = bus.ID_EX_Data1; o.d2 = bus.ID_EX_Data2; o.imm = bus.ID_EX_Imm;
    o.ctrl = bus.ID_EX_Ctrl; o.cnt = bus.Stall_Count;
    return o;
  endfunction

  function automatic obs_t mk(input int rs, rt, wa, input logic [31:0] d1, d2, imm,
                              input logic [7:0] ctrl, input int cnt);
    obs_t o;
    o.rs = 5'(rs); o.rt = 5'(rt); o.wa = 5'(wa);
    o.d1 = d1; o.d2 = d2; o.imm = imm; o.ctrl = ctrl; o.cnt = 16'(cnt);
    return o;
  endfunction

  task automatic drive(input int rs, rt, rd, input logic [31:0] d1, d2, imm,
                       input logic [7:0] ctrl, input logic fl, input logic hd);
    bus.IF_ID_RS = 5'(rs); bus.IF_ID_RT = 5'(rt); bus.IF_ID_RD = 5'(rd);
    bus.ID_Data1 = d1; bus.ID_Data2 = d2; bus.ID_Imm = imm;
    bus.ID_Ctrl = ctrl; bus.Flush = fl; bus.Hold = hd;
  endtask

  task automatic drive4(input int rs, rt, input logic [7:0] ctrl);
    bus4.IF_ID_RS = 5'(rs); bus4.IF_ID_RT = 5'(rt); bus4.IF_ID_RD = 5'd0;
    bus4.ID_Data1 = 32'h0; bus4.ID_Data2 = 32'h0; bus4.ID_Imm = 32'h0;
    bus4.ID_Ctrl = ctrl; bus4.Flush = 1'b0; bus4.Hold = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive4(0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            8'($urandom), 1'($urandom), 1'b0);
      cyc();
      act = obs(); vec++;
      if (act !== '0) begin errs++; $display("FAIL reset_regs act=%h exp=0", act); end
      vec++;
      if ({bus.PC_Write, bus.IF_ID_Write} !== 2'b11) begin
        errs++; $display("FAIL reset_we act=%b exp=11", {bus.PC_Write, bus.IF_ID_Write});
      end
    end
    vec++;
    if (bus4.Stall_Count !== 4'd0) begin errs++; $display("FAIL reset_cnt4 act=%0d exp=0", bus4.Stall_Count); end
    rst_n = 1'b1;
    drive(1, 5, 3, 32'hAAAA0001, 32'hBBBB0002, 32'hFFFF_FFF0, 8'h8C, 1'b0, 1'b0);
    sb.push_back(mk(1, 5, 3, 32'hAAAA0001, 32'hBBBB0002, 32'hFFFF_FFF0, 8'h8C, 0));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL reset_release act=%h exp=%h", act, exp_o); end
  endtask

  task automatic test_load_use();
    drive(2, 8, 0, 32'h11, 32'h22, 32'h4, 8'hE8, 1'b0, 1'b0);  // lw $8,4($2)
    sb.push_back(mk(2, 8, 8, 32'h11, 32'h22, 32'h4, 8'hE8, 0));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL lu_load act=%h exp=%h", act, exp_o); end
    drive(8, 9, 10, 32'h33, 32'h44, 32'h0, 8'h86, 1'b0, 1'b0); // add $10,$8,$9
    #1; vec++;
    if ({bus.PC_Write, bus.IF_ID_Write} !== 2'b00) begin
      errs++; $display("FAIL lu_stall_we act=%b exp=00", {bus.PC_Write, bus.IF_ID_Write});
    end
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL lu_bubble act=%h exp=%h", act, exp_o); end
    #1; vec++;
    if ({bus.PC_Write, bus.IF_ID_Write} !== 2'b11) begin
      errs++; $display("FAIL lu_one_cycle act=%b exp=11", {bus.PC_Write, bus.IF_ID_Write});
    end
    sb.push_back(mk(8, 9, 10, 32'h33, 32'h44, 32'h0, 8'h86, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL lu_dependent act=%h exp=%h", act, exp_o); end
  endtask

  task automatic test_zero_guard();
    drive(3, 0, 0, 32'h5, 32'h6, 32'h8, 8'hE8, 1'b0, 1'b0);    // lw $0,8($3)
    sb.push_back(mk(3, 0, 0, 32'h5, 32'h6, 32'h8, 8'hE8, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL zero_load act=%h exp=%h", act, exp_o); end
    drive(0, 4, 6, 32'h7, 32'h9, 32'h0, 8'h86, 1'b0, 1'b0);
    #1; vec++;
    if ({bus.PC_Write, bus.IF_ID_Write} !== 2'b11) begin
      errs++; $display("FAIL zero_guard_we act=%b exp=11", {bus.PC_Write, bus.IF_ID_Write});
    end
    sb.push_back(mk(0, 4, 6, 32'h7, 32'h9, 32'h0, 8'h86, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL zero_guard act=%h exp=%h", act, exp_o); end
  endtask

  task automatic test_flush_vs_lu();
    drive(1, 7, 0, 32'hC0, 32'hC1, 32'h10, 8'hE8, 1'b0, 1'b0);
    sb.push_back(mk(1, 7, 7, 32'hC0, 32'hC1, 32'h10, 8'hE8, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL flu_load act=%h exp=%h", act, exp_o); end
    drive(7, 2, 3, 32'hD0, 32'hD1, 32'h0, 8'h86, 1'b1, 1'b0);
    #1; vec++;
    if ({bus.PC_Write, bus.IF_ID_Write} !== 2'b11) begin
      errs++; $display("FAIL flush_over_lu_we act=%b exp=11", {bus.PC_Write, bus.IF_ID_Write});
    end
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL flush_over_lu act=%h exp=%h", act, exp_o); end
    drive(4, 5, 6, 32'hE0, 32'hE1, 32'h0, 8'h86, 1'b0, 1'b0);
    sb.push_back(mk(4, 5, 6, 32'hE0, 32'hE1, 32'h0, 8'h86, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL post_flush act=%h exp=%h", act, exp_o); end
  endtask

  task automatic test_hold_flush();
    obs_t held;
    held = mk(4, 5, 6, 32'hE0, 32'hE1, 32'h0, 8'h86, 1);
    for (int c = 0; c < 3; c++) begin
      drive(20 + c, 21, 22, $urandom, $urandom, $urandom, 8'h8C, (c == 1), 1'b1);
      #1; vec++;
      if ({bus.PC_Write, bus.IF_ID_Write} !== 2'b00) begin
        errs++; $display("FAIL hold_we act=%b exp=00", {bus.PC_Write, bus.IF_ID_Write});
      end
      sb.push_back(held);
      cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
      if (act !== exp_o) begin errs++; $display("FAIL hold_freeze act=%h exp=%h", act, exp_o); end
    end
    drive(12, 13, 14, 32'hF0, 32'hF1, 32'hF2, 8'h8C, 1'b0, 1'b0);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL hold_pend_flush act=%h exp=%h", act, exp_o); end
    sb.push_back(mk(12, 13, 14, 32'hF0, 32'hF1, 32'hF2, 8'h8C, 1));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL hold_resume act=%h exp=%h", act, exp_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      logic [4:0]  rs, rt, rd;
      logic [31:0] d1, d2, im;
      logic [7:0]  ct;
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      d1 = $urandom; d2 = $urandom; im = $urandom;
      ct = 8'($urandom) & 8'hDF;  // no loads: back-to-back captures only
      drive(rs, rt, rd, d1, d2, im, ct, 1'b0, 1'b0);
      sb.push_back(mk(rs, rt, ct[2] ? rd : rt, d1, d2, im, ct, 1));
      cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
      if (act !== exp_o) begin errs++; $display("FAIL b2b[%0d] act=%h exp=%h", i, act, exp_o); end
    end
  endtask

  // 4-bit counter instance: 17 load-use stalls must stop at 15
  task automatic test_saturation();
    drive4(8, 8, 8'hE8);
    for (int s = 1; s <= 17; s++) begin
      cyc();                                  // lw captured
      sb4.push_back((s > 15) ? 4'd15 : 4'(s));
      cyc();                                  // bubble
      vec++;
      if (bus4.Stall_Count !== sb4[0] || bus4.ID_EX_Ctrl !== 8'h00) begin
        errs++; $display("FAIL saturation[%0d] act=%0d/%h exp=%0d/00", s,
                         bus4.Stall_Count, bus4.ID_EX_Ctrl, sb4[0]);
      end
      void'(sb4.pop_front());
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 9, 0, 32'h91, 32'h92, 32'h93, 8'hE8, 1'b0, 1'b0);
    cyc();
    drive(9, 2, 11, 32'hA1, 32'hA2, 32'h0, 8'h86, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1; act = obs(); vec++;
    if (act !== '0 || {bus.PC_Write, bus.IF_ID_Write} !== 2'b11) begin
      errs++; $display("FAIL async_reset act=%h we=%b exp=0 we=11", act, {bus.PC_Write, bus.IF_ID_Write});
    end
    cyc();
    rst_n = 1'b1;
    sb.push_back(mk(9, 2, 11, 32'hA1, 32'hA2, 32'h0, 8'h86, 0));
    cyc(); act = obs(); exp_o = sb.pop_front(); vec++;
    if (act !== exp_o) begin errs++; $display("FAIL reset_mid_stall act=%h exp=%h", act, exp_o); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_guard();
    test_flush_vs_lu();
    test_hold_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection and bubble insertion built in. It captures decoded operands, register addresses and control bits from ID. It supplies ID_EX_RS, ID_EX_RT and the write-address/control fields to the EX stage and to the forwarding logic. It also drives the PC and IF/ID write-enables for stalls, and honours a downstream hold and a branch flush.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
IF_ID_RS  input  REG_AW  rs field of instruction in ID
IF_ID_RT  input  REG_AW  rt field of instruction in ID
IF_ID_RD  input  REG_AW  rd field of instruction in ID
ID_Data1  input  DATA_W  register file read port 1
ID_Data2  input  DATA_W  register file read port 2
ID_Imm  input  DATA_W  sign-extended immediate
ID_Ctrl  input  8  decoded control: [7]RegWrite [6]MemtoReg [5]MemRead [4]MemWrite [3]ALUSrc [2]RegDst [1:0]ALUOp
Flush  input  1  squash instruction in ID (taken branch/jump)
Hold  input  1  downstream stall; freeze ID/EX
ID_EX_RS  output  REG_AW  registered rs
ID_EX_RT  output  REG_AW  registered rt
ID_EX_RegWriteAdd  output  REG_AW  registered destination, RegDst ? rd : rt
ID_EX_Data1  output  DATA_W  registered operand 1
ID_EX_Data2  output  DATA_W  registered operand 2
ID_EX_Imm  output  DATA_W  registered immediate
ID_EX_Ctrl  output  8  registered control, same bit map as ID_Ctrl
PC_Write  output  1  PC update enable (combinational)
IF_ID_Write  output  1  IF/ID register update enable (combinational)
Stall_Count  output  CNT_W  number of load-use bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs, Stall_Count and flush_pend go to 0. PC_Write and IF_ID_Write then read 1.
- Load-use detect (combinational), LU:
  - Condition: ID_EX_Ctrl[5] & (ID_EX_RT != 0) & (ID_EX_RT == IF_ID_RS | ID_EX_RT == IF_ID_RT).
  - Deliberately conservative: stalls even when rt is only a destination in ID.
- Effective flush: FL = Flush | flush_pend.
- Write enables: PC_Write = IF_ID_Write = ~Hold & ~(LU & ~FL).
  - A flush overrides a load-use stall, because the ID instruction is wrong-path.
- Register update at each rising edge, in priority order:
  1. Hold=1: all ID/EX fields keep their values. If Flush=1, set flush_pend=1. Stall_Count unchanged.
  2. FL=1: bubble (Ctrl, RS, RT, RegWriteAdd, Data1, Data2, Imm all 0). Clear flush_pend.
  3. LU=1: bubble as above. Stall_Count += 1, saturating at all-ones.
  4. Otherwise, capture inputs. ID_EX_RegWriteAdd = ID_Ctrl[2] ? IF_ID_RD : IF_ID_RT.
- Bubbles zero RS/RT so the forwarding logic, which ignores register 0, never forwards into a bubble.
- A load-use bubble lasts exactly 1 cycle. The bubble clears ID_EX_Ctrl[5], so LU drops the next cycle and the dependent instruction enters EX while the load is in MEM/WB.
- Latency: 1 cycle from ID inputs to ID/EX outputs. No combinational path from ID_Data*/ID_Imm to outputs.
- Reset mid-stall: everything clears immediately; the next edge after release loads normally.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, PC_Write=1, IF_ID_Write=1, Stall_Count=0. Release -> next edge captures inputs; ID_Ctrl=8'h8C, rd=3, rt=5 gives RegWriteAdd=3.
- Load-use: load lw with rt=8 (ID_Ctrl=8'hE8) into ID/EX, then IF_ID_RS=8 ->
  - PC_Write=0 and IF_ID_Write=0 for exactly 1 cycle.
  - Next ID_EX_Ctrl=0 and ID_EX_RS=0.
  - Stall_Count=1.
  - Following cycle loads the dependent instruction.
- $0 guard: lw with rt=0, then IF_ID_RS=0 -> no stall, Stall_Count unchanged.
- Flush vs LU: LU condition and Flush=1 in the same cycle -> PC_Write=1, bubble inserted, Stall_Count unchanged.
- Hold with flush:
  - Hold=1 for 3 cycles with Flush pulsed in cycle 2 -> outputs frozen, PC_Write=0.
  - First edge after Hold=0 -> bubble even though Flush=0.
  - The edge after that loads normally.
- Saturation: preload 0xFFFE bubbles (CNT_W=16) and cause 3 more load-use stalls -> Stall_Count stops at 0xFFFF.
